regfile_writeback: RTL and testbench
====================================

REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-high reset; clears all state immediately, independent of clk.
REQ-003 SHALL have port: wb_valid  input  1  upstream offers a write-back request this cycle.
REQ-004 SHALL have port: wb_ready  output  1  block can accept a request this cycle.
REQ-005 SHALL have port: wb_rd  input  5  destination register index (31 = XZR).
REQ-006 SHALL have port: wb_data  input  64  result to be written.
REQ-007 SHALL have port: hold  input  1  downstream stall; suppresses commit this cycle.
REQ-008 SHALL have port: reg_write_enable  output  32  one-hot per-register write enable, bit i drives the write_enable of 64-bit register i.
REQ-009 SHALL have port: reg_in  output  64  shared write data to all 32 registers.
REQ-010 SHALL have port: pending_count  output  2  number of buffered requests (0..2).
REQ-011 SHALL have port: commit_cnt  output  16  count of committed requests (including dropped XZR writes).
REQ-012 SHALL have ports: ra1, ra2  input  5 each; byp_hit1, byp_hit2  output  1 each; byp_data1, byp_data2  output  64 each  (bypass query, see REQ-030).

Function
REQ-013 SHALL buffer requests in a 2-entry in-order FIFO (head = oldest), each entry holding rd[4:0] and data[63:0].
REQ-014 SHALL drive wb_ready = (pending_count < 2), from registered state only; no combinational path from wb_valid or hold.
REQ-015 SHALL accept a request at a rising edge where wb_valid && wb_ready; wb_rd/wb_data sampled at that edge.
REQ-016 SHALL commit when pending_count > 0 && !hold: reg_in = head.data; reg_write_enable = one-hot(head.rd) if head.rd != 31, else all zero.
REQ-017 SHALL drive reg_write_enable = 0 and reg_in = head.data (0 when empty) whenever no commit occurs.
REQ-018 SHALL pop the head at the rising edge ending a commit cycle; the destination register captures reg_in at that same edge.
REQ-019 SHALL yield latency: request accepted at edge N, with empty FIFO and hold low, updates the register at edge N+1.
REQ-020 SHALL handle simultaneous accept and commit with count 1 by keeping count at 1, new entry becoming head after pop.
REQ-021 SHALL refuse accept when full even if a commit occurs in the same cycle (wb_ready low).
REQ-022 SHALL leave all state unchanged when hold is high and no accept occurs.
REQ-023 SHALL increment commit_cnt by 1 per commit, wrapping 0xFFFF -> 0x0000.
REQ-024 SHALL never assert more than one reg_write_enable bit in any cycle.

Reset
REQ-025 SHALL, while reset is high, force pending_count = 0, commit_cnt = 0, reg_write_enable = 0, reg_in = 0, wb_ready = 0, byp_hit* = 0, byp_data* = 0.
REQ-026 SHALL discard buffered entries on reset mid-operation; no partial commit occurs at or after reset assertion.
REQ-027 SHALL assert wb_ready = 1 in the first cycle after reset deasserts.

Configuration
REQ-028 SHALL compile the bypass logic only when macro REGFILE_WB_BYPASS_EN is defined.
REQ-029 SHALL, without REGFILE_WB_BYPASS_EN, tie byp_hit1/2 = 0 and byp_data1/2 = 0 and ignore ra1/ra2.
REQ-030 SHALL, with REGFILE_WB_BYPASS_EN, set byp_hitK = 1 when raK != 31 and any buffered entry has rd == raK; byp_dataK = data of the youngest matching entry; else hit 0, data 0 (combinational on raK and buffered state).

Verification
REQ-031 SHALL cover: reset, then wb_rd=5, wb_data=0xFFFF_FFFF_FFFF_FFFF, one cycle -> next cycle reg_write_enable=0x0000_0020, reg_in=0xFFFF...F; commit_cnt=1.
REQ-032 SHALL cover: hold=1, push rd=3 and rd=7 -> pending_count=2, wb_ready=0, reg_write_enable=0; release hold -> enables 0x08 then 0x80 on consecutive cycles.
REQ-033 SHALL cover: push rd=31 data=0x1234 -> reg_write_enable stays 0, commit_cnt increments.
REQ-034 SHALL cover (bypass on): hold=1, push rd=4 data=0xA then rd=4 data=0xB, ra1=4 -> byp_hit1=1, byp_data1=0xB; ra2=31 -> byp_hit2=0.
REQ-035 SHALL cover: FIFO full with hold=1, assert reset mid-cycle -> outputs zero immediately; after release, no enable pulse for discarded entries.
REQ-036 SHALL cover: 65536 commits from 0 -> commit_cnt wraps to 0x0000.

Source files
------------

// File: rtl/regfile_writeback.sv
// regfile_writeback: 2-entry in-order write-back buffer feeding a 32 x 64-bit
// register file (one-hot enables, shared data bus), with optional read bypass.
// Ports:
//   clk, reset        clock; async active-high reset
//   wb_valid/wb_ready request handshake; wb_rd, wb_data request payload
//   hold              downstream stall, blocks commit
//   reg_write_enable  one-hot register enable (none for rd 31 = XZR)
//   reg_in            shared register write data (head entry, 0 if empty)
//   pending_count     buffered entries; commit_cnt wrapping commit counter
//   ra1/ra2, byp_hit1/2, byp_data1/2  bypass query of buffered entries
// Macro REGFILE_WB_BYPASS_EN enables the bypass logic; otherwise it is tied off.
module regfile_writeback (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [63:0] wb_data,
  input  logic        hold,
  output logic [31:0] reg_write_enable,
  output logic [63:0] reg_in,
  output logic [1:0]  pending_count,
  output logic [15:0] commit_cnt,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        byp_hit1,
  output logic        byp_hit2,
  output logic [63:0] byp_data1,
  output logic [63:0] byp_data2
);

  // Entry 0 is always the head (oldest); entry 1 the younger one.
  logic [1:0]        cnt_q, cnt_d;
  logic [1:0][4:0]   rd_q, rd_d;
  logic [1:0][63:0]  dat_q, dat_d;
  logic [15:0]       ccnt_q, ccnt_d;
  logic              commit;
  logic              accept;
  logic              slot;

  // Only the reset input gates readiness; no path from wb_valid or hold.
  assign wb_ready = ~reset & (cnt_q != 2'd2);

  assign commit = (cnt_q != 2'd0) & ~hold;
  assign accept = wb_valid & wb_ready;

  always_comb begin
    rd_d   = rd_q;
    dat_d  = dat_q;
    ccnt_d = ccnt_q;
    // New entry lands behind whatever survives this cycle's pop.
    slot   = (cnt_q == 2'd1) & ~commit;
    if (commit) begin
      rd_d[0]  = rd_q[1];
      dat_d[0] = dat_q[1];
      ccnt_d   = ccnt_q + 16'd1;
    end
    if (accept) begin
      rd_d[slot]  = wb_rd;
      dat_d[slot] = wb_data;
    end
    cnt_d = cnt_q - {1'b0, commit} + {1'b0, accept};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= 2'd0;
      rd_q   <= '0;
      dat_q  <= '0;
      ccnt_q <= 16'd0;
    end else begin
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      dat_q  <= dat_d;
      ccnt_q <= ccnt_d;
    end
  end

  always_comb begin
    reg_in           = (cnt_q != 2'd0) ? dat_q[0] : 64'd0;
    reg_write_enable = 32'd0;
    if (commit && rd_q[0] != 5'd31)
      reg_write_enable = 32'd1 << rd_q[0];
  end

  assign pending_count = cnt_q;
  assign commit_cnt    = ccnt_q;

`ifdef REGFILE_WB_BYPASS_EN
  // Returns {hit, data}; the younger entry wins when both match.
  function automatic logic [64:0] lookup(
    input logic [4:0]       ra,
    input logic [1:0]       cnt,
    input logic [1:0][4:0]  rd,
    input logic [1:0][63:0] dat
  );
    logic [64:0] r;
    r = 65'd0;
    if (ra != 5'd31) begin
      if (cnt == 2'd2 && rd[1] == ra)
        r = {1'b1, dat[1]};
      else if (cnt != 2'd0 && rd[0] == ra)
        r = {1'b1, dat[0]};
    end
    return r;
  endfunction

  always_comb begin
    {byp_hit1, byp_data1} = lookup(ra1, cnt_q, rd_q, dat_q);
    {byp_hit2, byp_data2} = lookup(ra2, cnt_q, rd_q, dat_q);
  end
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = 64'd0;
  assign byp_data2 = 64'd0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: randomized + directed bench for regfile_writeback,
// checked every cycle against a queue-based model of the write-back buffer.
module tb_regfile_writeback;

  logic        clk;
  logic        reset;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        hold;
  logic [31:0] reg_write_enable;
  logic [63:0] reg_in;
  logic [1:0]  pending_count;
  logic [15:0] commit_cnt;
  logic [4:0]  ra1, ra2;
  logic        byp_hit1, byp_hit2;
  logic [63:0] byp_data1, byp_data2;

  int checks = 0;
  int errors = 0;

  regfile_writeback dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_rd(wb_rd), .wb_data(wb_data), .hold(hold),
    .reg_write_enable(reg_write_enable), .reg_in(reg_in),
    .pending_count(pending_count), .commit_cnt(commit_cnt),
    .ra1(ra1), .ra2(ra2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of pending requests and a wrapping commit counter.
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] mcommit;
  bit          m_rdy, m_cm;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      mcommit = 16'd0;
    end else begin
      m_rdy = mq.size() < 2;
      m_cm  = mq.size() > 0 && !hold;
      if (m_cm) begin
        void'(mq.pop_front());
        mcommit = mcommit + 16'd1;
      end
      if (wb_valid && m_rdy) mq.push_back('{wb_rd, wb_data});
    end
  end

  logic [31:0] e_we;
  logic [63:0] e_in, e_d1, e_d2;
  logic        e_rdy, e_h1, e_h2;

  always @(negedge clk) begin
    e_rdy = !reset && mq.size() < 2;
    e_in  = (mq.size() > 0) ? mq[0].data : 64'd0;
    e_we  = 32'd0;
    if (mq.size() > 0 && !hold && mq[0].rd != 5'd31)
      e_we = 32'd1 << mq[0].rd;
    e_h1 = 1'b0; e_d1 = 64'd0;
    e_h2 = 1'b0; e_d2 = 64'd0;
`ifdef REGFILE_WB_BYPASS_EN
    foreach (mq[k]) begin
      if (ra1 != 5'd31 && mq[k].rd == ra1) begin
        e_h1 = 1'b1; e_d1 = mq[k].data;
      end
      if (ra2 != 5'd31 && mq[k].rd == ra2) begin
        e_h2 = 1'b1; e_d2 = mq[k].data;
      end
    end
`endif
    chk("m_ready", {63'd0, wb_ready}, {63'd0, e_rdy});
    chk("m_pending", {62'd0, pending_count}, 64'(mq.size()));
    chk("m_commit_cnt", {48'd0, commit_cnt}, {48'd0, mcommit});
    chk("m_we", {32'd0, reg_write_enable}, {32'd0, e_we});
    chk("m_reg_in", reg_in, e_in);
    chk("m_onehot", 64'($countones(reg_write_enable) <= 1), 64'd1);
    chk("m_hit1", {63'd0, byp_hit1}, {63'd0, e_h1});
    chk("m_data1", byp_data1, e_d1);
    chk("m_hit2", {63'd0, byp_hit2}, {63'd0, e_h2});
    chk("m_data2", byp_data2, e_d2);
  end

  task automatic drive(input logic v, input logic [4:0] rd,
                       input logic [63:0] d, input logic h);
    @(posedge clk);
    #1;
    wb_valid = v; wb_rd = rd; wb_data = d; hold = h;
  endtask

  initial begin
    clk = 0; reset = 1; wb_valid = 0; wb_rd = 0; wb_data = 0;
    hold = 0; ra1 = 0; ra2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pending", {62'd0, pending_count}, 64'd0);
    chk("rst_ready", {63'd0, wb_ready}, 64'd0);
    chk("rst_we", {32'd0, reg_write_enable}, 64'd0);
    chk("rst_reg_in", reg_in, 64'd0);
    chk("rst_cnt", {48'd0, commit_cnt}, 64'd0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("ready_after_reset", {63'd0, wb_ready}, 64'd1);

    // Single request to x5, committed the following cycle.
    drive(1, 5'd5, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    drive(0, 5'd0, 64'd0, 0);
    @(negedge clk);
    chk("x5_we", {32'd0, reg_write_enable}, 64'h20);
    chk("x5_reg_in", reg_in, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    chk("x5_cnt", {48'd0, commit_cnt}, 64'd1);
    chk("x5_we_done", {32'd0, reg_write_enable}, 64'd0);

    // Fill under hold, then drain in order.
    drive(1, 5'd3, 64'h33, 1);
    drive(1, 5'd7, 64'h77, 1);
    drive(0, 5'd0, 64'd0, 1);
    @(negedge clk);
    chk("full_pending", {62'd0, pending_count}, 64'd2);
    chk("full_ready", {63'd0, wb_ready}, 64'd0);
    chk("full_we", {32'd0, reg_write_enable}, 64'd0);
    drive(0, 5'd0, 64'd0, 0);
    @(negedge clk);
    chk("drain_we_x3", {32'd0, reg_write_enable}, 64'h08);
    @(negedge clk);
    chk("drain_we_x7", {32'd0, reg_write_enable}, 64'h80);
    @(negedge clk);
    chk("drain_cnt", {48'd0, commit_cnt}, 64'd3);

    // XZR write is dropped but still counted.
    drive(1, 5'd31, 64'h1234, 0);
    drive(0, 5'd0, 64'd0, 0);
    @(negedge clk);
    chk("xzr_we", {32'd0, reg_write_enable}, 64'd0);
    chk("xzr_reg_in", reg_in, 64'h1234);
    @(negedge clk);
    chk("xzr_cnt", {48'd0, commit_cnt}, 64'd4);

    // Two writes to x4 buffered; query bypass.
    ra1 = 5'd4; ra2 = 5'd31;
    drive(1, 5'd4, 64'hA, 1);
    drive(1, 5'd4, 64'hB, 1);
    drive(0, 5'd0, 64'd0, 1);
    @(negedge clk);
`ifdef REGFILE_WB_BYPASS_EN
    chk("byp_hit1", {63'd0, byp_hit1}, 64'd1);
    chk("byp_data1", byp_data1, 64'hB);
`else
    chk("byp_hit1_off", {63'd0, byp_hit1}, 64'd0);
    chk("byp_data1_off", byp_data1, 64'd0);
`endif
    chk("byp_hit2", {63'd0, byp_hit2}, 64'd0);

    // Reset mid-cycle with a full FIFO.
    #2 reset = 1;
    #1;
    chk("mid_rst_pending", {62'd0, pending_count}, 64'd0);
    chk("mid_rst_we", {32'd0, reg_write_enable}, 64'd0);
    chk("mid_rst_reg_in", reg_in, 64'd0);
    chk("mid_rst_ready", {63'd0, wb_ready}, 64'd0);
    chk("mid_rst_byp", byp_data1, 64'd0);
    drive(0, 5'd0, 64'd0, 0);
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("post_rst_ready", {63'd0, wb_ready}, 64'd1);
    chk("post_rst_we", {32'd0, reg_write_enable}, 64'd0);
    @(negedge clk);
    chk("post_rst_we2", {32'd0, reg_write_enable}, 64'd0);

    // 65536 back-to-back commits wrap the counter.
    @(posedge clk); #1;
    wb_valid = 1; hold = 0;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk); #1;
      wb_rd = 5'($urandom); wb_data = {$urandom, $urandom};
    end
    wb_valid = 0;
    @(negedge clk);
    chk("wrap_ffff", {48'd0, commit_cnt}, 64'hFFFF);
    @(negedge clk);
    chk("wrap_zero", {48'd0, commit_cnt}, 64'd0);

    // Random traffic, with one asynchronous reset along the way.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        @(negedge clk);
        #2 reset = 1;
        @(posedge clk); #1 reset = 0;
      end
      drive(($urandom % 4) != 0,
            (($urandom % 5) == 0) ? 5'd31 : 5'($urandom % 8),
            {$urandom, $urandom}, ($urandom % 3) == 0);
      ra1 = (($urandom % 6) == 0) ? 5'd31 : 5'($urandom % 8);
      ra2 = 5'($urandom % 8);
    end
    drive(0, 5'd0, 64'd0, 0);
    repeat (3) @(negedge clk);
    chk("final_empty", {62'd0, pending_count}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
